// File: rtl/execute_flag_sequencer_pkg.sv
// Shared types and constants for the execute-stage flag write-back sequencer.
package execute_flag_sequencer_pkg;

  localparam int FLAG_W    = 5;
  localparam int NUM_UNITS = 4;

  typedef logic [FLAG_W-1:0] flag_t;

  typedef enum logic [1:0] {
    FLAG_UNIT_SHIFT = 2'd0,
    FLAG_UNIT_ADDER = 2'd1,
    FLAG_UNIT_MUL   = 2'd2,
    FLAG_UNIT_LOGIC = 2'd3
  } flag_unit_e;

  localparam flag_t FLAG_RESET_VALUE = 5'h00;

endpackage

// File: rtl/execute_flag_sequencer_if.sv
// Issue handshake and execute-unit completion bus feeding the flag sequencer.
interface execute_flag_sequencer_if;
  import execute_flag_sequencer_pkg::*;

  logic       iISSUE_VALID;
  logic       iISSUE_FLAG_WRITE;
  logic [1:0] iISSUE_UNIT;
  logic       oISSUE_READY;

  logic       iSHIFT_VALID;
  flag_t      iSHIFT_FLAG;
  logic       iADDER_VALID;
  flag_t      iADDER_FLAG;
  logic       iMUL_VALID;
  flag_t      iMUL_FLAG;
  logic       iLOGIC_VALID;
  flag_t      iLOGIC_FLAG;

  modport master (
    output iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    output iSHIFT_VALID, iSHIFT_FLAG, iADDER_VALID, iADDER_FLAG,
    output iMUL_VALID, iMUL_FLAG, iLOGIC_VALID, iLOGIC_FLAG,
    input  oISSUE_READY
  );

  modport slave (
    input  iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    input  iSHIFT_VALID, iSHIFT_FLAG, iADDER_VALID, iADDER_FLAG,
    input  iMUL_VALID, iMUL_FLAG, iLOGIC_VALID, iLOGIC_FLAG,
    output oISSUE_READY
  );
endinterface

// File: rtl/execute_flag_unit_queue.sv
// In-order FIFO of unit IDs for outstanding flag-writing instructions.
module execute_flag_unit_queue
  import execute_flag_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iFLUSH,
  input  logic             iPUSH,
  input  flag_unit_e       iPUSH_UNIT,
  input  logic             iPOP,
  output flag_unit_e       oHEAD_UNIT,
  output logic [DEPTH_W:0] oCOUNT,
  output logic             oFULL,
  output logic             oEMPTY
);

  localparam logic [DEPTH_W:0] FULL_COUNT = DEPTH[DEPTH_W:0];

  flag_unit_e         mem [DEPTH];
  logic [DEPTH_W-1:0] wrPtr;
  logic [DEPTH_W-1:0] rdPtr;
  logic [DEPTH_W:0]   count;
  logic               doPush;
  logic               doPop;

  assign oFULL      = (count == FULL_COUNT);
  assign oEMPTY     = (count == '0);
  assign oCOUNT     = count;
  assign oHEAD_UNIT = mem[rdPtr];

  assign doPush = iPUSH && !oFULL;
  assign doPop  = iPOP && !oEMPTY;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= FLAG_UNIT_SHIFT;
    end else if (iFLUSH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iPUSH_UNIT;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/execute_flag_sequencer.sv
// Commits execute-unit flag results to the architectural flag register in issue order.
module execute_flag_sequencer
  import execute_flag_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iCTRL_HOLD,
  input  logic                    iPFLAGR_VALID,
  input  flag_t                   iPFLAGR,
  execute_flag_sequencer_if.slave bus,
  output flag_t                   oFLAG,
  output logic                    oFLAG_BUSY,
  output logic                    oOVERFLOW_ERR
);

  logic             liveValid  [NUM_UNITS];
  flag_t            liveFlag   [NUM_UNITS];
  logic             latchValid [NUM_UNITS];
  flag_t            latchFlag  [NUM_UNITS];

  flag_unit_e       headUnit;
  logic [DEPTH_W:0] qCount;
  logic             qFull;
  logic             qEmpty;
  logic             normalMode;
  logic             push;
  logic             commit;
  flag_t            commitFlag;
  logic [NUM_UNITS-1:0] latchTaken;
  logic [NUM_UNITS-1:0] liveTaken;

  always_comb begin
    liveValid[FLAG_UNIT_SHIFT] = bus.iSHIFT_VALID;
    liveFlag [FLAG_UNIT_SHIFT] = bus.iSHIFT_FLAG;
    liveValid[FLAG_UNIT_ADDER] = bus.iADDER_VALID;
    liveFlag [FLAG_UNIT_ADDER] = bus.iADDER_FLAG;
    liveValid[FLAG_UNIT_MUL]   = bus.iMUL_VALID;
    liveFlag [FLAG_UNIT_MUL]   = bus.iMUL_FLAG;
    liveValid[FLAG_UNIT_LOGIC] = bus.iLOGIC_VALID;
    liveFlag [FLAG_UNIT_LOGIC] = bus.iLOGIC_FLAG;
  end

  assign normalMode       = !iRESET_SYNC && !iPFLAGR_VALID && !iCTRL_HOLD;
  assign bus.oISSUE_READY = !qFull && !iCTRL_HOLD;
  assign push             = bus.iISSUE_VALID && bus.iISSUE_FLAG_WRITE && bus.oISSUE_READY
                            && !iRESET_SYNC && !iPFLAGR_VALID;
  assign oFLAG_BUSY       = (qCount != '0);

  // A held result for the head always wins over a live one; the live one then refills the latch.
  always_comb begin
    commit     = 1'b0;
    commitFlag = latchFlag[headUnit];
    latchTaken = '0;
    liveTaken  = '0;
    if (normalMode && !qEmpty) begin
      if (latchValid[headUnit]) begin
        commit               = 1'b1;
        commitFlag           = latchFlag[headUnit];
        latchTaken[headUnit] = 1'b1;
      end else if (liveValid[headUnit]) begin
        commit              = 1'b1;
        commitFlag          = liveFlag[headUnit];
        liveTaken[headUnit] = 1'b1;
      end
    end
  end

  execute_flag_unit_queue #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) uQueue (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iFLUSH     (iRESET_SYNC || iPFLAGR_VALID),
    .iPUSH      (push),
    .iPUSH_UNIT (flag_unit_e'(bus.iISSUE_UNIT)),
    .iPOP       (commit),
    .oHEAD_UNIT (headUnit),
    .oCOUNT     (qCount),
    .oFULL      (qFull),
    .oEMPTY     (qEmpty)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oFLAG         <= FLAG_RESET_VALUE;
      oOVERFLOW_ERR <= 1'b0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        latchValid[u] <= 1'b0;
        latchFlag[u]  <= FLAG_RESET_VALUE;
      end
    end else if (iRESET_SYNC) begin
      oFLAG         <= FLAG_RESET_VALUE;
      oOVERFLOW_ERR <= 1'b0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        latchValid[u] <= 1'b0;
        latchFlag[u]  <= FLAG_RESET_VALUE;
      end
    end else if (iPFLAGR_VALID) begin
      oFLAG <= iPFLAGR;
      for (int unsigned u = 0; u < NUM_UNITS; u++) latchValid[u] <= 1'b0;
    end else begin
      if (commit) oFLAG <= commitFlag;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        if (latchTaken[u]) begin
          latchValid[u] <= liveValid[u];
          if (liveValid[u]) latchFlag[u] <= liveFlag[u];
        end else if (liveValid[u] && !liveTaken[u]) begin
          if (latchValid[u]) oOVERFLOW_ERR <= 1'b1;
          else begin
            latchValid[u] <= 1'b1;
            latchFlag[u]  <= liveFlag[u];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_flag_sequencer.sv
// Directed and randomized checks of the flag sequencer against a queue-based reference model.
module tb_execute_flag_sequencer;
  import execute_flag_sequencer_pkg::*;

  localparam int DEPTH = 4;

  logic  iCLOCK;
  logic  inRESET;
  logic  iRESET_SYNC;
  logic  iCTRL_HOLD;
  logic  iPFLAGR_VALID;
  flag_t iPFLAGR;
  flag_t oFLAG;
  logic  oFLAG_BUSY;
  logic  oOVERFLOW_ERR;

  execute_flag_sequencer_if bus ();

  execute_flag_sequencer #(
    .DEPTH   (DEPTH),
    .DEPTH_W (2)
  ) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iRESET_SYNC   (iRESET_SYNC),
    .iCTRL_HOLD    (iCTRL_HOLD),
    .iPFLAGR_VALID (iPFLAGR_VALID),
    .iPFLAGR       (iPFLAGR),
    .bus           (bus.slave),
    .oFLAG         (oFLAG),
    .oFLAG_BUSY    (oFLAG_BUSY),
    .oOVERFLOW_ERR (oOVERFLOW_ERR)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  int unsigned assertCount = 0;
  int unsigned failCount   = 0;

  // Reference model: program-order list of pending units, one parked result per unit.
  int unsigned mq[$];
  bit          latV [4];
  logic [4:0]  latF [4];
  logic [4:0]  mFlag;
  bit          mOvf;

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    for (int u = 0; u < 4; u++) latV[u] = 1'b0;
    mFlag = 5'h00;
    mOvf  = 1'b0;
  endtask

  task automatic setIdle();
    iRESET_SYNC           = 1'b0;
    iCTRL_HOLD            = 1'b0;
    iPFLAGR_VALID         = 1'b0;
    iPFLAGR               = 5'h00;
    bus.iISSUE_VALID      = 1'b0;
    bus.iISSUE_FLAG_WRITE = 1'b0;
    bus.iISSUE_UNIT       = 2'd0;
    bus.iSHIFT_VALID      = 1'b0;
    bus.iSHIFT_FLAG       = 5'h00;
    bus.iADDER_VALID      = 1'b0;
    bus.iADDER_FLAG       = 5'h00;
    bus.iMUL_VALID        = 1'b0;
    bus.iMUL_FLAG         = 5'h00;
    bus.iLOGIC_VALID      = 1'b0;
    bus.iLOGIC_FLAG       = 5'h00;
  endtask

  task automatic issue(input int unsigned unit);
    bus.iISSUE_VALID      = 1'b1;
    bus.iISSUE_FLAG_WRITE = 1'b1;
    bus.iISSUE_UNIT       = unit[1:0];
  endtask

  task automatic modelStep();
    bit          lv [4];
    logic [4:0]  lf [4];
    bit          ready;
    bit          usedLive;
    int unsigned h;
    lv[0] = bus.iSHIFT_VALID; lf[0] = bus.iSHIFT_FLAG;
    lv[1] = bus.iADDER_VALID; lf[1] = bus.iADDER_FLAG;
    lv[2] = bus.iMUL_VALID;   lf[2] = bus.iMUL_FLAG;
    lv[3] = bus.iLOGIC_VALID; lf[3] = bus.iLOGIC_FLAG;
    ready = (mq.size() < DEPTH) && !iCTRL_HOLD;
    if (iRESET_SYNC) begin
      modelClear();
    end else if (iPFLAGR_VALID) begin
      mFlag = iPFLAGR;
      mq.delete();
      for (int u = 0; u < 4; u++) latV[u] = 1'b0;
    end else begin
      usedLive = 1'b0;
      h        = 4;
      if (!iCTRL_HOLD && mq.size() > 0) begin
        h = mq[0];
        if (latV[h]) begin
          mFlag   = latF[h];
          latV[h] = 1'b0;
          void'(mq.pop_front());
        end else if (lv[h]) begin
          mFlag    = lf[h];
          usedLive = 1'b1;
          void'(mq.pop_front());
        end
      end
      for (int u = 0; u < 4; u++) begin
        if (lv[u] && !(usedLive && u == h)) begin
          if (latV[u]) mOvf = 1'b1;
          else begin
            latV[u] = 1'b1;
            latF[u] = lf[u];
          end
        end
      end
      if (ready && bus.iISSUE_VALID && bus.iISSUE_FLAG_WRITE) mq.push_back(int'(bus.iISSUE_UNIT));
    end
  endtask

  // Inputs are applied just after a falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic runCycle();
    #1;
    checkValue("issueReady", {31'd0, bus.oISSUE_READY}, {31'd0, (mq.size() < DEPTH) && !iCTRL_HOLD});
    modelStep();
    @(posedge iCLOCK);
    #1;
    checkValue("flag", {27'd0, oFLAG}, {27'd0, mFlag});
    checkValue("busy", {31'd0, oFLAG_BUSY}, {31'd0, mq.size() != 0});
    checkValue("overflow", {31'd0, oOVERFLOW_ERR}, {31'd0, mOvf});
    @(negedge iCLOCK);
    setIdle();
  endtask

  task automatic syncReset();
    iRESET_SYNC = 1'b1;
    runCycle();
  endtask

  initial begin
    setIdle();
    modelClear();
    inRESET = 1'b0;
    #3;
    checkValue("resetFlag", {27'd0, oFLAG}, 32'h0);
    checkValue("resetBusy", {31'd0, oFLAG_BUSY}, 32'h0);
    checkValue("resetOvf", {31'd0, oOVERFLOW_ERR}, 32'h0);
    checkValue("resetReady", {31'd0, bus.oISSUE_READY}, 32'h1);
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    inRESET = 1'b1;

    // Single adder op, completes the cycle after issue.
    issue(FLAG_UNIT_ADDER); runCycle();
    checkValue("adderBusy", {31'd0, oFLAG_BUSY}, 32'h1);
    bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h03; runCycle();
    checkValue("adderFlag", {27'd0, oFLAG}, 32'h03);
    checkValue("adderIdle", {31'd0, oFLAG_BUSY}, 32'h0);

    // Mul then adder, adder finishes first.
    issue(FLAG_UNIT_MUL); runCycle();
    issue(FLAG_UNIT_ADDER); bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h04; runCycle();
    runCycle();
    bus.iMUL_VALID = 1'b1; bus.iMUL_FLAG = 5'h11; runCycle();
    checkValue("mulFirst", {27'd0, oFLAG}, 32'h11);
    runCycle();
    checkValue("adderSecond", {27'd0, oFLAG}, 32'h04);
    checkValue("noOverflow", {31'd0, oOVERFLOW_ERR}, 32'h0);

    // Fill the queue, refuse a fifth issue, free a slot.
    for (int i = 0; i < 4; i++) begin issue(FLAG_UNIT_LOGIC); runCycle(); end
    checkValue("fullNotReady", {31'd0, bus.oISSUE_READY}, 32'h0);
    issue(FLAG_UNIT_SHIFT); runCycle();
    bus.iLOGIC_VALID = 1'b1; bus.iLOGIC_FLAG = 5'h07; runCycle();
    checkValue("readyAfterPop", {31'd0, bus.oISSUE_READY}, 32'h1);
    syncReset();

    // Adder latch overflow while mul holds the head.
    issue(FLAG_UNIT_MUL); runCycle();
    issue(FLAG_UNIT_ADDER); runCycle();
    issue(FLAG_UNIT_ADDER); bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h05; runCycle();
    bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h06; runCycle();
    checkValue("overflowSet", {31'd0, oOVERFLOW_ERR}, 32'h1);
    runCycle(); runCycle();
    checkValue("overflowSticky", {31'd0, oOVERFLOW_ERR}, 32'h1);
    syncReset();

    // Flag restore flushes pending work and drops a concurrent completion.
    issue(FLAG_UNIT_SHIFT); runCycle();
    issue(FLAG_UNIT_ADDER); runCycle();
    iPFLAGR_VALID = 1'b1; iPFLAGR = 5'h1A; bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = 5'h09; runCycle();
    checkValue("restoreFlag", {27'd0, oFLAG}, 32'h1A);
    checkValue("restoreIdle", {31'd0, oFLAG_BUSY}, 32'h0);
    runCycle();
    checkValue("restoreDiscard", {27'd0, oFLAG}, 32'h1A);

    // Hold across the head completion, then release.
    issue(FLAG_UNIT_SHIFT); runCycle();
    iCTRL_HOLD = 1'b1; bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = 5'h15; runCycle();
    iCTRL_HOLD = 1'b1; runCycle();
    iCTRL_HOLD = 1'b1; runCycle();
    checkValue("holdFrozen", {27'd0, oFLAG}, 32'h1A);
    runCycle();
    checkValue("holdRelease", {27'd0, oFLAG}, 32'h15);
    issue(FLAG_UNIT_SHIFT); runCycle();
    iCTRL_HOLD = 1'b1; bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = 5'h0C; runCycle();
    iRESET_SYNC = 1'b1; iCTRL_HOLD = 1'b1; runCycle();
    checkValue("syncClearFlag", {27'd0, oFLAG}, 32'h0);
    runCycle();
    checkValue("syncClearLatch", {27'd0, oFLAG}, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      iRESET_SYNC           = ($urandom_range(0, 199) == 0);
      iPFLAGR_VALID         = ($urandom_range(0, 49) == 0);
      iPFLAGR               = 5'($urandom_range(0, 31));
      iCTRL_HOLD            = ($urandom_range(0, 7) == 0);
      bus.iISSUE_VALID      = ($urandom_range(0, 1) == 1);
      bus.iISSUE_FLAG_WRITE = ($urandom_range(0, 3) != 0);
      bus.iISSUE_UNIT       = 2'($urandom_range(0, 3));
      bus.iSHIFT_VALID      = ($urandom_range(0, 3) == 0);
      bus.iSHIFT_FLAG       = 5'($urandom_range(0, 31));
      bus.iADDER_VALID      = ($urandom_range(0, 3) == 0);
      bus.iADDER_FLAG       = 5'($urandom_range(0, 31));
      bus.iMUL_VALID        = ($urandom_range(0, 5) == 0);
      bus.iMUL_FLAG         = 5'($urandom_range(0, 31));
      bus.iLOGIC_VALID      = ($urandom_range(0, 3) == 0);
      bus.iLOGIC_FLAG       = 5'($urandom_range(0, 31));
      runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/execute_flag_sequencer.md
Name: execute_flag_sequencer

Overview:
- Orders flag write-back from the execute-stage units (shift, adder, mul, logic) into the architectural 5-bit flag register.
- Units may complete out of order: mul is multi-cycle, the others are single-cycle.
- Keeps an in-order queue of flag-writing instructions and commits each unit's flags only when that instruction reaches the queue head.
- Owns the flag register. Exposes the committed flags and a busy indication so dependent consumers (branch/condition logic) can stall.

Parameters:
- DEPTH, 4, number of outstanding flag-writing instructions (power of two, ≥2)
- DEPTH_W, 2, log2(DEPTH)

Ports:
- iCLOCK  in  1  clock, rising edge
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear, active-high
- iCTRL_HOLD  in  1  freezes commits and issue acceptance
- iPFLAGR_VALID  in  1  flag restore (exception return/flush)
- iPFLAGR  in  5  restore value
- iISSUE_VALID  in  1  instruction issued to execute
- iISSUE_FLAG_WRITE  in  1  issued instruction writes flags
- iISSUE_UNIT  in  2  0=shift, 1=adder, 2=mul, 3=logic
- oISSUE_READY  out  1  queue can accept a flag-writing issue
- iSHIFT_VALID / iSHIFT_FLAG  in  1/5  shift completion
- iADDER_VALID / iADDER_FLAG  in  1/5  adder completion
- iMUL_VALID / iMUL_FLAG  in  1/5  mul completion
- iLOGIC_VALID / iLOGIC_FLAG  in  1/5  logic completion
- oFLAG  out  5  committed flag register
- oFLAG_BUSY  out  1  ≥1 flag write outstanding
- oOVERFLOW_ERR  out  1  sticky: completion lost

Behaviour:
- Reset (inRESET low, async): queue empty, all holding latches invalid, oFLAG=5'h00, oOVERFLOW_ERR=0, oFLAG_BUSY=0, oISSUE_READY=1.
- Per-cycle priority: async reset > iRESET_SYNC > iPFLAGR_VALID > iCTRL_HOLD > normal.
- iRESET_SYNC:
  - Same effect as reset at the next edge.
  - Overrides every other input that cycle.
- iPFLAGR_VALID:
  - oFLAG<=iPFLAGR; queue flushed (count=0, pointers 0); all latches invalidated.
  - Issue and completions that cycle are discarded. oOVERFLOW_ERR is unchanged.
- Queue:
  - Circular buffer of 2-bit unit IDs with read/write pointers (DEPTH_W bits, wrap mod DEPTH) and a count (DEPTH_W+1 bits).
  - oISSUE_READY = (count<DEPTH) && !iCTRL_HOLD. This is combinational; there is no same-cycle pop bypass.
  - Push when iISSUE_VALID && iISSUE_FLAG_WRITE && oISSUE_READY.
  - Issues with iISSUE_FLAG_WRITE=0 are ignored.
- Holding latches:
  - One per unit: a valid bit plus 5-bit flags.
  - A unit completion that is not consumed by a commit in the same cycle is written into that unit's latch.
  - Capture continues during iCTRL_HOLD.
  - Completion while that latch is already valid and not consumed that cycle: new data dropped, latch keeps the older value, oOVERFLOW_ERR<=1 (sticky until reset/iRESET_SYNC).
  - Completion from a unit with no queued entry is latched the same way.
- Commit (normal mode, count>0):
  - Let H = unit at the head.
  - Source is latch[H] if valid, otherwise the live H completion.
  - If a source exists: oFLAG<=source flags, pop head, clear latch[H].
  - If latch[H] and live H completion are both present: commit the latch, and the live value refills latch[H] in the same edge (no overflow).
  - At most one commit per cycle. Latency from head completion to oFLAG update is 1 cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- iCTRL_HOLD: no commit, no push, oFLAG held; latches still capture.
- oFLAG_BUSY = (count!=0), registered-state derived (combinational from count).

Decomposition:
- Shared package:
  - unit-ID constants FLAG_UNIT_SHIFT=0, FLAG_UNIT_ADDER=1, FLAG_UNIT_MUL=2, FLAG_UNIT_LOGIC=3
  - FLAG_W=5
  - flag reset value 5'h00
- Sub-module execute_flag_unit_queue: the DEPTH-entry 2-bit ID FIFO with push/pop/flush, count, full/empty.
- The top level holds the latches, commit mux and flag register.

Test Plan:
- Reset, then issue adder (ID 1), then iADDER_VALID with 5'h03 next cycle -> oFLAG=5'h03 one cycle later; oFLAG_BUSY 1→0.
- Issue mul then adder. Adder completes 5'h04 at t+1, mul completes 5'h11 at t+3 -> oFLAG=5'h11 at t+4 then 5'h04 at t+5; no overflow.
- Issue 4 flag writers with no completions -> oISSUE_READY=0; a fifth issue is not accepted. Completing the head -> ready returns the cycle after the pop.
- Issue 2 adder ops. Hold adder latch full, then a further iADDER_VALID with the head being mul -> oOVERFLOW_ERR=1 and stays set.
- Two entries pending, iPFLAGR_VALID with 5'h1A together with iSHIFT_VALID -> oFLAG=5'h1A, oFLAG_BUSY=0, shift result discarded.
- iCTRL_HOLD for 3 cycles while the head's completion arrives -> oFLAG unchanged during hold; committed 1 cycle after hold drops. Same sequence with iRESET_SYNC -> oFLAG=5'h00.
